spi_slave_gen: RTL and testbench

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_tx_shifter.sv | 72 +++++++
 rtl/spi_slave_gen.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding and the
// two-bit command codes carried at the top of every received frame.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    // Width of a counter that must be able to hold the value n itself
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-to-serial MISO shifter: loads one DATA_W word and emits it MSB first.
// busy_o (bits still pending after the current one) exists only with SPI_FRAME_ERR_EN.
module spi_tx_shifter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              abort_i,
    output logic              miso_o
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              busy_o
`endif
);

    localparam int unsigned CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              act_q, act_d;
    logic              miso_q, miso_d;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        miso_d = miso_q;
        if (abort_i) begin
            sh_d   = '0;
            cnt_d  = '0;
            act_d  = 1'b0;
            miso_d = 1'b0;
        end else if (load_i) begin
            // First bit goes straight to the line; the rest wait in sh_q
            act_d  = 1'b1;
            miso_d = data_i[DATA_W-1];
            sh_d   = {data_i[DATA_W-2:0], 1'b0};
            cnt_d  = CW'(DATA_W - 1);
        end else if (act_q) begin
            if (cnt_q == '0) begin
                act_d  = 1'b0;
                miso_d = 1'b0;
            end else begin
                miso_d = sh_q[DATA_W-1];
                sh_d   = {sh_q[DATA_W-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;
`ifdef SPI_FRAME_ERR_EN
    assign busy_o = act_q && (cnt_q != '0);
`endif

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave: command check, RX_W-bit frame receive, read-address tracking and MISO readback.
// Optional frame_err abort indicator is built when SPI_FRAME_ERR_EN is defined.
module spi_slave_gen
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MOSI,
    input  logic              SS_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int unsigned      RX_W    = DATA_W + 2;
    localparam int unsigned      CNT_W   = cnt_width(RX_W);
    localparam logic [CNT_W-1:0] LastBit = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(RX_W);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RX_W-2:0]  shift_q, shift_d;
    logic [RX_W-1:0]  rx_data_q, rx_data_d;
    logic [RX_W-1:0]  frame_bits;
    logic             rx_valid_q, rx_valid_d;
    logic             rd_addr_done_q, rd_addr_done_d;
    logic             wait_tx_q, wait_tx_d;
    logic             armed_q, armed_d;
    logic             tx_load, tx_abort;
`ifdef SPI_FRAME_ERR_EN
    logic             frame_err_q, frame_err_d;
    logic             tx_busy;
`endif

    always_comb begin
        frame_bits     = {shift_q, MOSI};
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        // A deselect cancels any pending readback; a tx_valid in that cycle is lost
        wait_tx_d      = wait_tx_q & ~SS_n;
        // Frames are only accepted after SS_n has been seen high since reset
        armed_d        = armed_q | SS_n;
        tx_load        = 1'b0;
        tx_abort       = SS_n;
`ifdef SPI_FRAME_ERR_EN
        frame_err_d    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (!SS_n && armed_q) begin
                    state_d = CHK_CMD;
                end
            end
            CHK_CMD: begin
                cnt_d   = '0;
                shift_d = '0;
                if (SS_n) begin
                    state_d = IDLE;
                end else if (!MOSI) begin
                    state_d = WRITE;
                end else if (rd_addr_done_q) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef SPI_FRAME_ERR_EN
                    frame_err_d = (cnt_q != FullCnt) | wait_tx_q | tx_busy;
`endif
                end else begin
                    // Bits beyond a full frame are dropped until deselect
                    if (cnt_q != FullCnt) begin
                        shift_d = frame_bits[RX_W-2:0];
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LastBit) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = frame_bits;
                            if (state_q == READ_ADD) begin
                                rd_addr_done_d = 1'b1;
                            end
                            if (state_q == READ_DATA) begin
                                rd_addr_done_d = 1'b0;
                                wait_tx_d      = 1'b1;
                            end
                        end
                    end
                    if (wait_tx_q && tx_valid) begin
                        tx_load   = 1'b1;
                        wait_tx_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            wait_tx_q      <= 1'b0;
            armed_q        <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            wait_tx_q      <= wait_tx_d;
            armed_q        <= armed_d;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q    <= frame_err_d;
`endif
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tx_load),
        .data_i  (tx_data),
        .abort_i (tx_abort),
        .miso_o  (MISO)
`ifdef SPI_FRAME_ERR_EN
        ,
        .busy_o  (tx_busy)
`endif
    );

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
`ifdef SPI_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen: frame-level reference model fills per-cycle
// expectation tables, one negedge process compares; directed cases pin literal values.
module tb_spi_slave_gen;
    import spi_slave_pkg::*;

    localparam int DW   = 8;
    localparam int RW   = DW + 2;
    localparam int NCYC = 16384;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          MOSI = 1'b0;
    logic          SS_n = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          MISO, rx_valid;
    logic [RW-1:0] rx_data;

    logic          ss2 = 1'b1;
    logic          mosi2 = 1'b0;
    logic          miso2, rxv2;
    logic [17:0]   rxd2;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err, frame_err2;
`endif

    spi_slave_gen #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .MISO     (MISO),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    spi_slave_gen #(.DATA_W(16)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .MOSI     (mosi2),
        .SS_n     (ss2),
        .tx_valid (1'b0),
        .tx_data  (16'h0000),
        .MISO     (miso2),
        .rx_valid (rxv2),
        .rx_data  (rxd2)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err2)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cap_edge = -1000;
    int rxv_count = 0;
    int miso_ones = 0;
    logic [DW-1:0] miso_cap = '0;

    bit            exp_rxv  [NCYC];
    logic [RW-1:0] exp_rxd  [NCYC];
    bit            exp_miso [NCYC];
    bit            exp_ferr [NCYC];
    logic [RW-1:0] held_rxd = '0;

    bit m_rd_done = 1'b0;
    bit m_armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expectation tables
    always @(negedge clk) begin
        if (!rst_n) begin
            held_rxd = '0;
        end else begin
            if (exp_rxv[cyc]) held_rxd = exp_rxd[cyc];
            check("rx_valid", rx_valid, exp_rxv[cyc]);
            check("rx_data", rx_data, held_rxd);
            check("miso", MISO, exp_miso[cyc]);
`ifdef SPI_FRAME_ERR_EN
            check("frame_err", frame_err, exp_ferr[cyc]);
`endif
            if (rx_valid) rxv_count++;
            if (MISO) miso_ones++;
            if (cyc >= cap_edge && cyc < cap_edge + DW) miso_cap[DW-1-(cyc-cap_edge)] = MISO;
        end
    end

    function automatic bit nz();
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [DW-1:0] rd();
        return DW'($urandom);
    endfunction

    task automatic step(input bit ss, input bit mosi, input bit txv, input logic [DW-1:0] txd);
        SS_n = ss;
        MOSI = mosi;
        tx_valid = txv;
        tx_data = txd;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // One select period. nbits frame bits follow the command bit; extra bits beyond RW are
    // random. For a read-data frame: txdly<0 never supplies tx_valid (and a tx_valid rides the
    // deselect edge, which must be lost); cut=0 lets MISO finish, cut=k deselects k cycles
    // after the tx capture.
    task automatic frame(input bit cmd, input logic [RW-1:0] bits, input int nbits,
                         input int txdly, input logic [DW-1:0] txd, input int cut);
        int  kind;
        int  e;
        int  n;
        bit  done;
        bit  b;
        done = 1'b0;
        step(1'b0, rb(), nz(), rd());
        kind = !cmd ? 0 : (m_rd_done ? 2 : 1);
        step(1'b0, cmd, nz(), rd());
        for (int i = 0; i < nbits; i++) begin
            e = cyc + 1;
            b = (i < RW) ? bits[RW-1-i] : rb();
            if (i == RW - 1) begin
                exp_rxv[e] = 1'b1;
                exp_rxd[e] = bits;
                done = 1'b1;
                if (kind == 1) m_rd_done = 1'b1;
                if (kind == 2) m_rd_done = 1'b0;
            end
            step(1'b0, b, (kind == 2 && i >= RW) ? 1'b0 : nz(), rd());
        end
        if (kind == 2 && done) begin
            if (txdly < 0) begin
                repeat ($urandom_range(0, 2)) step(1'b0, rb(), 1'b0, rd());
                e = cyc + 1;
                exp_ferr[e] = 1'b1;
                step(1'b1, rb(), 1'b1, txd);
            end else begin
                repeat (txdly) step(1'b0, rb(), 1'b0, rd());
                e = cyc + 1;
                cap_edge = e;
                n = (cut == 0) ? DW : cut;
                for (int j = 0; j < n; j++) exp_miso[e+j] = txd[DW-1-j];
                step(1'b0, rb(), 1'b1, txd);
                if (cut == 0) begin
                    repeat (DW - 1 + $urandom_range(0, 2)) step(1'b0, rb(), nz(), rd());
                    step(1'b1, rb(), nz(), rd());
                end else begin
                    repeat (cut - 1) step(1'b0, rb(), nz(), rd());
                    e = cyc + 1;
                    if (cut < DW) exp_ferr[e] = 1'b1;
                    step(1'b1, rb(), nz(), rd());
                end
            end
        end else begin
            e = cyc + 1;
            if (nbits < RW) exp_ferr[e] = 1'b1;
            step(1'b1, rb(), nz(), rd());
        end
        repeat ($urandom_range(0, 2)) step(1'b1, rb(), nz(), rd());
        m_armed = 1'b1;
    endtask

    // Asynchronous reset pulse; outputs must drop before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_miso", MISO, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, '0);
        for (int k = cyc; k < cyc + 40; k++) begin
            exp_rxv[k] = 1'b0;
            exp_miso[k] = 1'b0;
            exp_ferr[k] = 1'b0;
        end
        m_rd_done = 1'b0;
        m_armed = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int m0;
        int e;
        logic [RW-1:0] fr;
        for (int k = 0; k < NCYC; k++) begin
            exp_rxv[k] = 1'b0;
            exp_rxd[k] = '0;
            exp_miso[k] = 1'b0;
            exp_ferr[k] = 1'b0;
        end
        @(negedge clk);
        #1;
        check("reset_miso", MISO, 1'b0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        m_armed = 1'b1;

        // Write frame
        c0 = rxv_count;
        m0 = miso_ones;
        frame(1'b0, {WR_ADDR, 8'hA5}, RW, 0, '0, 0);
        check("wr_rx_data", rx_data, 10'h0A5);
        check("wr_rxv_count", rxv_count - c0, 1);
        check("wr_no_miso", miso_ones - m0, 0);

        // Read address then read data
        frame(1'b1, {RD_ADDR, 8'h3C}, RW, 0, '0, 0);
        check("rd_addr_done_set", dut.rd_addr_done_q, 1'b1);
        check("rd_addr_rx_data", rx_data, 10'h23C);
        frame(1'b1, {RD_DATA, 8'h00}, RW, 2, 8'hC3, 0);
        check("rd_miso_bits", miso_cap, 8'hC3);
        check("rd_addr_done_clr", dut.rd_addr_done_q, 1'b0);

        // Abort after 5 write bits
        c0 = rxv_count;
        frame(1'b0, {WR_DATA, 8'h5A}, 5, 0, '0, 0);
        check("abort_state", dut.state_q, IDLE);
        check("abort_rxv_count", rxv_count - c0, 0);

        // Read without a prior address goes to READ_ADD
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        m_armed = 1'b1;
        m0 = miso_ones;
        frame(1'b1, {RD_DATA, 8'hFF}, RW, 0, 8'hFF, 0);
        check("noaddr_rd_done", dut.rd_addr_done_q, 1'b1);
        check("noaddr_no_miso", miso_ones - m0, 0);

        // Reset while MISO is shifting, released with SS_n still low
        fr = {RD_DATA, 8'h11};
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < RW; i++) begin
            e = cyc + 1;
            if (i == RW - 1) begin
                exp_rxv[e] = 1'b1;
                exp_rxd[e] = fr;
                m_rd_done = 1'b0;
            end
            step(1'b0, fr[RW-1-i], 1'b0, '0);
        end
        e = cyc + 1;
        for (int j = 0; j < 3; j++) exp_miso[e+j] = 1'b1;
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        check("pre_reset_miso", MISO, 1'b1);
        do_reset();
        c0 = rxv_count;
        repeat (RW + 3) step(1'b0, rb(), 1'b0, '0);
        check("post_reset_ignored", rxv_count - c0, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        m_armed = 1'b1;
        frame(1'b0, {WR_DATA, 8'h55}, RW, 0, '0, 0);
        check("post_reset_wr", rx_data, 10'h155);

        // 16-bit payload instance
        ss2 = 1'b0;
        step(1'b1, 1'b0, 1'b0, '0);
        mosi2 = 1'b0;
        step(1'b1, 1'b0, 1'b0, '0);
        begin
            logic [17:0] f16;
            f16 = 18'h1ABCD;
            for (int i = 0; i < 18; i++) begin
                mosi2 = f16[17-i];
                step(1'b1, 1'b0, 1'b0, '0);
                if (i == 16) check("w16_no_early_valid", rxv2, 1'b0);
            end
        end
        check("w16_rx_valid", rxv2, 1'b1);
        check("w16_rx_data", rxd2, 18'h1ABCD);
        step(1'b1, 1'b0, 1'b0, '0);
        check("w16_valid_one_cycle", rxv2, 1'b0);
        ss2 = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);

        // Randomized frames
        for (int f = 0; f < 150 && cyc < NCYC - 100; f++) begin
            int r;
            int nb;
            int td;
            int ct;
            r = $urandom_range(0, 19);
            nb = (r < 14) ? RW : (r < 17) ? RW + $urandom_range(1, 3) : $urandom_range(0, RW - 1);
            td = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
            ct = $urandom_range(0, 1) ? 0 : $urandom_range(1, DW);
            frame(rb(), RW'($urandom), nb, td, rd(), ct);
        end
        step(1'b1, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
